ram_bus_controller: RTL and testbench
=====================================

# ram_bus_controller

Sequencer and address decoder between the CPU data bus and port B of the shared 4096×16 dual-port block RAM. It decodes CPU accesses into RAM reads and writes or memory-mapped peripheral accesses (digital tube, buttons, IR code registers), and stalls the CPU with a ready handshake. It also runs a hardware RAM-clear sweep on CPU request. Port A, the VGA read-only side, is not touched.

## Interface
Parameters:
- ADDR_W, 12, bus/RAM address width
- DATA_W, 16, data width
- TUBE_ADDR, 110, digital tube register address (read/write)
- BTN_ADDR, 111, button address (read-only)
- IRH_ADDR, 112, IR code high half (read-only)
- IRL_ADDR, 113, IR code low half (read-only)
- CLEAR_DEPTH, 4096, words zeroed by a clear sweep

Ports:
- clk  in  1  system clock; the block uses one clock
- res  in  1  reset, synchronous, active-low
- cpu_sel  in  1  CPU bus request
- cpu_load  in  1  1 = read, 0 = write
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_clr  in  1  RAM clear request
- cpu_rdata  out  DATA_W  read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high while a clear sweep runs
- clr_done  out  1  one-cycle pulse at the end of a sweep
- ram_addr  out  ADDR_W  RAM port B address
- ram_wdata  out  DATA_W  RAM port B write data
- ram_we  out  1  RAM port B write enable
- ram_q  in  DATA_W  RAM port B read data; valid one clock after the address is presented
- btns  in  4  push buttons, active-low
- ir_high, ir_low  in  DATA_W each  latched IR code halves
- tube_value  out  DATA_W  digital tube display register

## Operation
- States: IDLE, RD_ADDR, RD_WAIT, RESP, CLEAR.
- IDLE decision, evaluated in priority order:
  1. If cpu_clr=1, go to CLEAR and reset the counter to 0.
  2. If cpu_sel=1 with a RAM address (any address other than the four mapped ones) and cpu_load=1, latch ram_addr and go to RD_ADDR.
  3. If cpu_sel=1 with a RAM address and cpu_load=0, register ram_addr, ram_wdata and ram_we=1, then go to RESP.
  4. If cpu_sel=1 with a mapped address and cpu_load=1, register cpu_rdata and go to RESP. The read value is tube_value, {12'h000, ~btns}, ir_high or ir_low, by address.
  5. If cpu_sel=1 with TUBE_ADDR and cpu_load=0, set tube_value to cpu_wdata and go to RESP.
  6. If cpu_sel=1 with another mapped address and cpu_load=0, discard the write and go to RESP.
- RD_ADDR: hold the address, ram_we=0, go to RD_WAIT.
- RD_WAIT: cpu_rdata <= ram_q, go to RESP.
- RESP: cpu_ready=1 and ram_we=0. cpu_sel is ignored in this cycle; return to IDLE.
- CLEAR:
  - Each cycle drives ram_we=1, ram_wdata=0, ram_addr=counter, then increments the counter.
  - After the write at CLEAR_DEPTH-1, return to IDLE with clr_done=1 for one cycle.
  - busy=1 throughout CLEAR. cpu_ready stays 0. cpu_clr and cpu_sel are ignored.
- cpu_rdata holds its last value until the next read completes. Writes never change it.
- The counter is ADDR_W+1 bits wide, so it does not wrap before terminating at CLEAR_DEPTH-1.

## Timing
- The request is sampled at edge E0 in IDLE.
- RAM write: ram_we=1 during the cycle after E0, with cpu_ready=1 in the same cycle. Writes run at most one every 2 cycles.
- RAM read: ram_addr is valid after E0. ram_q is valid after E1 and captured at E2. cpu_ready=1 together with valid cpu_rdata in the cycle after E2, which is 3 cycles of latency.
- Peripheral read or write: cpu_ready and the updated cpu_rdata or tube_value appear in the cycle after E0.
- Clear: the first ram_we is in the cycle after E0. The sweep takes exactly CLEAR_DEPTH consecutive write cycles, followed by a 1-cycle clr_done.
- Reset (res=0 at an edge) forces:
  - state IDLE, counter 0
  - cpu_rdata=0, cpu_ready=0, busy=0, clr_done=0
  - ram_addr=0, ram_wdata=0, ram_we=0
  - tube_value=0
- Reset mid-sweep aborts the sweep immediately. RAM is left partially cleared and no clr_done is issued.
- Reset mid-read drops the transaction with no cpu_ready.

## Test plan
- Write 16'hBEEF to address 5, then read address 5: ram_we pulses once with addr 5 and data BEEF. The read yields cpu_rdata=16'hBEEF, with cpu_ready 3 cycles after the sample edge.
- Write 16'h1234 to address 110, then read 110: tube_value=16'h1234 one cycle after sampling; ram_we never asserts; the read returns 16'h1234.
- With btns=4'b1010, read address 111 to get 16'h0005. Then write 16'hFFFF to 111: only cpu_ready pulses, with no RAM write and no state change.
- Pulse cpu_clr with CLEAR_DEPTH=4096: busy=1 for 4096 cycles, ram_we=1 for addresses 0..4095 with data 0, clr_done pulses once. cpu_sel held high meanwhile gets no cpu_ready until after clr_done.
- cpu_clr and cpu_sel asserted together in IDLE: the clear wins, and the pending access completes afterwards.
- res=0 at sweep cycle 100: all outputs reach their reset values the next cycle, ram_we stops, and no clr_done is issued.

Source files
------------

// File: rtl/ram_bus_controller.sv
// ram_bus_controller
// Bridges the CPU data bus to port B of the shared dual-port block RAM.
// It decodes each CPU access as a RAM read, a RAM write or a
// memory-mapped peripheral access: the digital tube, the buttons or the
// IR code halves. It stalls the CPU until a one-cycle cpu_ready pulse.
// It also runs a hardware sweep that zeroes the RAM when the CPU asks.
// All outputs are registered. The reset is synchronous and active-low.

module ram_bus_controller #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int TUBE_ADDR   = 110,
    parameter int BTN_ADDR    = 111,
    parameter int IRH_ADDR    = 112,
    parameter int IRL_ADDR    = 113,
    parameter int CLEAR_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cpu_sel,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_clr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    input  logic [3:0]        btns,
    input  logic [DATA_W-1:0] ir_high,
    input  logic [DATA_W-1:0] ir_low,
    output logic [DATA_W-1:0] tube_value
);

    localparam logic [ADDR_W-1:0] TUBE_A = ADDR_W'(TUBE_ADDR);
    localparam logic [ADDR_W-1:0] BTN_A  = ADDR_W'(BTN_ADDR);
    localparam logic [ADDR_W-1:0] IRH_A  = ADDR_W'(IRH_ADDR);
    localparam logic [ADDR_W-1:0] IRL_A  = ADDR_W'(IRL_ADDR);

    // The counter always points one word ahead of the word being written.
    // The sweep therefore ends when the counter reaches CLEAR_DEPTH.
    // The extra counter bit lets it hold CLEAR_DEPTH without wrapping.
    localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(CLEAR_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        RESP,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   counter;
    logic              is_tube;
    logic              is_mapped;
    logic [DATA_W-1:0] periph_rdata;

    // Decode the mapped peripheral addresses and select their read value
    always_comb begin
        is_tube      = (cpu_addr == TUBE_A);
        is_mapped    = 1'b1;
        periph_rdata = '0;
        if (cpu_addr == TUBE_A) begin
            periph_rdata = tube_value;
        end else if (cpu_addr == BTN_A) begin
            periph_rdata = {{(DATA_W - 4){1'b0}}, ~btns};
        end else if (cpu_addr == IRH_A) begin
            periph_rdata = ir_high;
        end else if (cpu_addr == IRL_A) begin
            periph_rdata = ir_low;
        end else begin
            is_mapped = 1'b0;
        end
    end

    // Access sequencer and clear sweep, with every output registered
    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= IDLE;
            counter    <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            busy       <= 1'b0;
            clr_done   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            tube_value <= '0;
        end else begin
            cpu_ready <= 1'b0;
            clr_done  <= 1'b0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_clr) begin
                        // Write word 0 in the first cycle. The counter then moves on to word 1.
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                        busy      <= 1'b1;
                        counter   <= {{ADDR_W{1'b0}}, 1'b1};
                        state     <= CLEAR;
                    end else if (cpu_sel) begin
                        if (!is_mapped) begin
                            ram_addr <= cpu_addr;
                            if (cpu_load) begin
                                state <= RD_ADDR;
                            end else begin
                                ram_wdata <= cpu_wdata;
                                ram_we    <= 1'b1;
                                cpu_ready <= 1'b1;
                                state     <= RESP;
                            end
                        end else begin
                            if (cpu_load) begin
                                cpu_rdata <= periph_rdata;
                            end else if (is_tube) begin
                                tube_value <= cpu_wdata;
                            end
                            cpu_ready <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RD_ADDR: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    cpu_rdata <= ram_q;
                    cpu_ready <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (counter == CLR_END) begin
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_addr  <= counter[ADDR_W-1:0];
                        ram_wdata <= '0;
                        busy      <= 1'b1;
                        counter   <= counter + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_controller.sv
// tb_ram_bus_controller
// Directed test of ram_bus_controller against a small behavioural model
// of the block RAM port B. The model has a one-cycle read latency.

module tb_ram_bus_controller;

    logic        clk;
    logic        res;
    logic        cpu_sel;
    logic        cpu_load;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_clr;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        busy;
    logic        clr_done;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_q;
    logic [3:0]  btns;
    logic [15:0] ir_high;
    logic [15:0] ir_low;
    logic [15:0] tube_value;

    int n_compared   = 0;
    int n_mismatched = 0;
    int we_count     = 0;
    int done_count   = 0;

    logic [15:0] mem [0:4095];

    ram_bus_controller dut (
        .clk        (clk),
        .res        (res),
        .cpu_sel    (cpu_sel),
        .cpu_load   (cpu_load),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_clr    (cpu_clr),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .busy       (busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .btns       (btns),
        .ir_high    (ir_high),
        .ir_low     (ir_low),
        .tube_value (tube_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM port B model: a synchronous write and a registered read that returns the old data
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // Count the RAM write cycles and clr_done pulses seen at each edge
    always @(posedge clk) begin
        if (ram_we === 1'b1) we_count++;
        if (clr_done === 1'b1) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sel, input logic load,
                                  input logic [11:0] addr, input logic [15:0] wdata);
        cpu_sel   = sel;
        cpu_load  = load;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int we_snap;
        int done_snap;
        int bad;

        res     = 1'b0;
        cpu_clr = 1'b0;
        btns    = 4'b1111;
        ir_high = 16'hA5A5;
        ir_low  = 16'h5A5A;
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        tick();
        tick();
        check_output("reset_rdata", cpu_rdata, 0);
        check_output("reset_ready", cpu_ready, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_clr_done", clr_done, 0);
        check_output("reset_ram_addr", ram_addr, 0);
        check_output("reset_ram_wdata", ram_wdata, 0);
        check_output("reset_ram_we", ram_we, 0);
        check_output("reset_tube", tube_value, 0);
        res = 1'b1;
        tick();

        $display("[TB] RAM write then read at address 5");
        we_snap = we_count;
        apply_stimulus(1'b1, 1'b0, 12'd5, 16'hBEEF);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("wr5_we", ram_we, 1);
        check_output("wr5_addr", ram_addr, 12'd5);
        check_output("wr5_wdata", ram_wdata, 16'hBEEF);
        check_output("wr5_ready", cpu_ready, 1);
        tick();
        check_output("wr5_we_drop", ram_we, 0);
        check_output("wr5_ready_drop", cpu_ready, 0);
        check_output("wr5_we_pulses", we_count - we_snap, 1);
        apply_stimulus(1'b1, 1'b1, 12'd5, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("rd5_e0_addr", ram_addr, 12'd5);
        check_output("rd5_e0_we", ram_we, 0);
        check_output("rd5_e0_ready", cpu_ready, 0);
        tick();
        check_output("rd5_e1_ready", cpu_ready, 0);
        tick();
        check_output("rd5_ready", cpu_ready, 1);
        check_output("rd5_rdata", cpu_rdata, 16'hBEEF);
        tick();
        check_output("rd5_ready_drop", cpu_ready, 0);

        $display("[TB] Tube register write and read");
        we_snap = we_count;
        apply_stimulus(1'b1, 1'b0, 12'd110, 16'h1234);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("tube_wr_value", tube_value, 16'h1234);
        check_output("tube_wr_ready", cpu_ready, 1);
        check_output("tube_wr_we", ram_we, 0);
        tick();
        apply_stimulus(1'b1, 1'b1, 12'd110, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("tube_rd_ready", cpu_ready, 1);
        check_output("tube_rd_rdata", cpu_rdata, 16'h1234);
        tick();
        check_output("tube_no_ram_we", we_count - we_snap, 0);

        $display("[TB] Buttons and IR code registers");
        btns = 4'b1010;
        apply_stimulus(1'b1, 1'b1, 12'd111, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("btn_rd_ready", cpu_ready, 1);
        check_output("btn_rd_rdata", cpu_rdata, 16'h0005);
        tick();
        we_snap = we_count;
        apply_stimulus(1'b1, 1'b0, 12'd111, 16'hFFFF);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("btn_wr_ready", cpu_ready, 1);
        check_output("btn_wr_we", ram_we, 0);
        check_output("btn_wr_rdata_kept", cpu_rdata, 16'h0005);
        check_output("btn_wr_tube_kept", tube_value, 16'h1234);
        tick();
        check_output("btn_wr_no_ram_we", we_count - we_snap, 0);
        apply_stimulus(1'b1, 1'b1, 12'd112, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("irh_rdata", cpu_rdata, 16'hA5A5);
        tick();
        apply_stimulus(1'b1, 1'b1, 12'd113, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("irl_rdata", cpu_rdata, 16'h5A5A);
        tick();

        $display("[TB] Clear sweep with a read to address 5 pending");
        we_snap   = we_count;
        done_snap = done_count;
        cpu_clr   = 1'b1;
        apply_stimulus(1'b1, 1'b1, 12'd5, 16'h0000);
        tick();
        cpu_clr = 1'b0;
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'(i) ||
                ram_wdata !== 16'h0000 || cpu_ready !== 1'b0 || clr_done !== 1'b0) begin
                bad++;
            end
            tick();
        end
        check_output("clr_bad_cycles", bad, 0);
        check_output("clr_done_pulse", clr_done, 1);
        check_output("clr_busy_end", busy, 0);
        check_output("clr_we_end", ram_we, 0);
        check_output("clr_ready_end", cpu_ready, 0);
        check_output("clr_we_cycles", we_count - we_snap, 4096);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("clr_done_once", clr_done, 0);
        check_output("clr_pend_addr", ram_addr, 12'd5);
        check_output("clr_pend_ready_e0", cpu_ready, 0);
        tick();
        tick();
        check_output("clr_pend_ready", cpu_ready, 1);
        check_output("clr_pend_rdata", cpu_rdata, 16'h0000);
        tick();
        check_output("clr_done_count", done_count - done_snap, 1);

        $display("[TB] Reset during a clear sweep");
        done_snap = done_count;
        cpu_clr   = 1'b1;
        tick();
        cpu_clr = 1'b0;
        repeat (100) tick();
        check_output("abort_addr_100", ram_addr, 12'd100);
        check_output("abort_busy_100", busy, 1);
        res = 1'b0;
        tick();
        res = 1'b1;
        check_output("abort_rdata", cpu_rdata, 0);
        check_output("abort_ready", cpu_ready, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_clr_done", clr_done, 0);
        check_output("abort_ram_addr", ram_addr, 0);
        check_output("abort_ram_wdata", ram_wdata, 0);
        check_output("abort_ram_we", ram_we, 0);
        check_output("abort_tube", tube_value, 0);
        we_snap = we_count;
        repeat (10) tick();
        check_output("abort_no_we", we_count - we_snap, 0);
        check_output("abort_no_done", done_count - done_snap, 0);

        $display("[TB] Top RAM address after reset");
        apply_stimulus(1'b1, 1'b0, 12'd4095, 16'h0042);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        check_output("wr_top_we", ram_we, 1);
        check_output("wr_top_addr", ram_addr, 12'd4095);
        tick();
        apply_stimulus(1'b1, 1'b1, 12'd4095, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, 12'd0, 16'h0000);
        tick();
        tick();
        check_output("rd_top_ready", cpu_ready, 1);
        check_output("rd_top_rdata", cpu_rdata, 16'h0042);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
